tone_envelope_shaper: RTL and testbench

//  Downstream stage of the phase-accumulator tone generator. Takes the 8-bit phase (accumulator bits [23:16])
//  and shapes it into one of four waveforms. Scales the result by an ADSR envelope driven by a key gate.

---
 rtl/tone_envelope_shaper.sv | 266 ++++++++++++++++++++++++++
 tb/tb_tone_envelope_shaper.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_envelope_shaper.sv
//-----------------------------------------------------------------------------
// tone_envelope_shaper
// Takes the 8-bit phase from the tone generator and turns it into one of four
// waveforms. The ADSR envelope, driven by the key gate, scales that waveform.
// The enveloped sample is emitted as an 8-bit value and as a first-order
// sigma-delta bit stream for an external RC filter.
//
// Pipeline: phase_in -> raw_q (stage 1) -> sample_out (stage 2) -> pwm_out.
// The envelope value is sampled at stage 2.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tone_envelope_shaper #(
    parameter int TICK_DIV = 16        // clocks per envelope tick, >= 1
) (
    input  logic       clk,
    input  logic       reset,          // synchronous, active-high
    input  logic [7:0] phase_in,
    input  logic [1:0] wave_sel,
    input  logic       gate,
    input  logic [3:0] attack_rate,
    input  logic [3:0] decay_rate,
    input  logic [3:0] sustain_lvl,
    input  logic [3:0] release_rate,
    output logic [7:0] sample_out,
    output logic [7:0] env_out,
    output logic [2:0] env_state,
    output logic       pwm_out
);

    // Prescaler width; a TICK_DIV of 1 still needs a 1-bit counter.
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    typedef enum logic [1:0] {
        WAVE_SAW      = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_PULSE25  = 2'd3
    } wave_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q;
    logic [3:0]    sub_q;
    env_state_e    state_q;
    logic [7:0]    env_q;
    logic [7:0]    raw_q;
    logic [7:0]    sample_q;
    logic [7:0]    sd_acc_q;
    logic          pwm_q;

    // Next-state / combinational values
    logic          tick;
    logic          step;
    logic [3:0]    rate;
    logic [7:0]    sustain_target;
    logic [7:0]    raw_d;
    logic [15:0]   prod;
    logic [7:0]    sample_d;
    logic [8:0]    sd_sum;

    // ------------------------------------------------------------------
    // Envelope timebase
    // ------------------------------------------------------------------

    // Free-running prescaler producing one tick every TICK_DIV clocks.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples its inputs at the same edge regardless of statement order.
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_q == TICK_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == TICK_LAST);

    // Select the step divider belonging to the current envelope phase.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        rate = 4'd0;
        case (state_q)
            ST_ATTACK:  rate = attack_rate;
            ST_DECAY:   rate = decay_rate;
            ST_RELEASE: rate = release_rate;
            default:    rate = 4'd0;
        endcase
    end

    // The envelope moves one unit after (rate+1) ticks in the current phase.
    assign step           = tick && (sub_q == rate);
    assign sustain_target = {sustain_lvl, sustain_lvl};

    // ------------------------------------------------------------------
    // ADSR state machine, envelope value and tick sub-counter
    // ------------------------------------------------------------------

    // Envelope FSM: rows are checked in priority order; any state change
    // restarts the sub-counter so a new phase always gets a full interval.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            env_q   <= 8'd0;
            sub_q   <= 4'd0;
        end else begin
            // Baseline sub-counter behaviour; the later assignments below
            // (step, state change) take precedence as the last write wins.
            if (tick) begin
                sub_q <= sub_q + 4'd1;
            end
            if (step) begin
                sub_q <= 4'd0;
            end

            case (state_q)
                ST_IDLE: begin
                    env_q <= 8'd0;
                    if (gate) begin
                        state_q <= ST_ATTACK;
                        sub_q   <= 4'd0;
                    end
                end

                ST_ATTACK: begin
                    if (!gate) begin
                        state_q <= ST_RELEASE;
                        sub_q   <= 4'd0;
                    end else if (env_q == 8'hFF) begin
                        state_q <= ST_DECAY;
                        sub_q   <= 4'd0;
                    end else if (step) begin
                        env_q <= env_q + 8'd1;
                    end
                end

                ST_DECAY: begin
                    if (!gate) begin
                        state_q <= ST_RELEASE;
                        sub_q   <= 4'd0;
                    end else if (env_q <= sustain_target) begin
                        state_q <= ST_SUSTAIN;
                        sub_q   <= 4'd0;
                    end else if (step) begin
                        env_q <= env_q - 8'd1;
                    end
                end

                ST_SUSTAIN: begin
                    // Envelope is frozen here; sustain_lvl is only a target
                    // for the decay phase, not a live level.
                    if (!gate) begin
                        state_q <= ST_RELEASE;
                        sub_q   <= 4'd0;
                    end
                end

                ST_RELEASE: begin
                    // Retrigger keeps the current level to avoid a click.
                    if (gate) begin
                        state_q <= ST_ATTACK;
                        sub_q   <= 4'd0;
                    end else if (env_q == 8'd0) begin
                        state_q <= ST_IDLE;
                        sub_q   <= 4'd0;
                    end else if (step) begin
                        env_q <= env_q - 8'd1;
                    end
                end

                default: begin
                    // Unreachable encodings recover to a silent idle.
                    state_q <= ST_IDLE;
                    env_q   <= 8'd0;
                    sub_q   <= 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Waveform shaping (stage 1)
    // ------------------------------------------------------------------

    // Map the phase to the selected waveform.
    always_comb begin
        raw_d = phase_in;
        case (wave_e'(wave_sel))
            WAVE_SAW:      raw_d = phase_in;
            WAVE_SQUARE:   raw_d = phase_in[7] ? 8'h00 : 8'hFF;
            WAVE_TRIANGLE: raw_d = phase_in[7] ? ~{phase_in[6:0], 1'b0}
                                               :  {phase_in[6:0], 1'b0};
            WAVE_PULSE25:  raw_d = (phase_in[7:6] == 2'b00) ? 8'hFF : 8'h00;
            default:       raw_d = phase_in;
        endcase
    end

    // Register the shaped waveform.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q <= 8'd0;
        end else begin
            raw_q <= raw_d;
        end
    end

    // ------------------------------------------------------------------
    // Envelope scaling (stage 2)
    // ------------------------------------------------------------------

    // Unsigned 8x8 multiply keeping the upper byte; full scale maps to 254.
    always_comb begin
        prod     = 16'(raw_q) * 16'(env_q);
        sample_d = 8'(prod >> 8);
    end

    // Register the enveloped sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q <= 8'd0;
        end else begin
            sample_q <= sample_d;
        end
    end

    // ------------------------------------------------------------------
    // First-order sigma-delta modulator
    // ------------------------------------------------------------------

    // The carry out of the 8-bit accumulator is the output bit, giving a
    // ones density of sample_out/256.
    assign sd_sum = {1'b0, sd_acc_q} + {1'b0, sample_q};

    // Accumulate the sample and register the carry as the pin value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sd_acc_q <= 8'd0;
            pwm_q    <= 1'b0;
        end else begin
            sd_acc_q <= sd_sum[7:0];
            pwm_q    <= sd_sum[8];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sample_out = sample_q;
    assign env_out    = env_q;
    assign env_state  = state_q;
    assign pwm_out    = pwm_q;

endmodule

// File: tb/tb_tone_envelope_shaper.sv
//-----------------------------------------------------------------------------
// Self-checking bench for tone_envelope_shaper.
// Two instances: dut (TICK_DIV=1) for most scenarios, dut4 (TICK_DIV=4) for
// the envelope timebase. Waveform samples go through a scoreboard queue whose
// entries are due two clocks after the phase is driven.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tone_envelope_shaper;

    logic       clk = 1'b0;
    logic       reset;
    logic       reset4;
    logic [7:0] phase_in;
    logic [1:0] wave_sel;
    logic       gate;
    logic       gate4;
    logic [3:0] attack_rate;
    logic [3:0] decay_rate;
    logic [3:0] sustain_lvl;
    logic [3:0] release_rate;

    logic [7:0] sample_out,  sample_out4;
    logic [7:0] env_out,     env_out4;
    logic [2:0] env_state,   env_state4;
    logic       pwm_out,     pwm_out4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    always #5 clk = ~clk;

    tone_envelope_shaper #(.TICK_DIV(1)) dut (
        .clk(clk), .reset(reset), .phase_in(phase_in), .wave_sel(wave_sel),
        .gate(gate), .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_lvl(sustain_lvl), .release_rate(release_rate),
        .sample_out(sample_out), .env_out(env_out), .env_state(env_state),
        .pwm_out(pwm_out)
    );

    tone_envelope_shaper #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset4), .phase_in(phase_in), .wave_sel(wave_sel),
        .gate(gate4), .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_lvl(sustain_lvl), .release_rate(release_rate),
        .sample_out(sample_out4), .env_out(env_out4), .env_state(env_state4),
        .pwm_out(pwm_out4)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        string      tag;
        int         due;
        logic [7:0] exp;
    } sb_t;

    sb_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference waveform and envelope scaling.
    function automatic logic [7:0] model_sample(input logic [1:0] w, input logic [7:0] p,
                                                input logic [7:0] env);
        logic [7:0]  raw;
        logic [15:0] prod;
        case (w)
            2'd0:    raw = p;
            2'd1:    raw = p[7] ? 8'h00 : 8'hFF;
            2'd2:    raw = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            default: raw = (p[7:6] == 2'b00) ? 8'hFF : 8'h00;
        endcase
        prod = 16'(raw) * 16'(env);
        return prod[15:8];
    endfunction

    // Advance one clock, sample just after the edge, retire due entries.
    task automatic tick_clk();
        @(posedge clk);
        #1;
        cyc++;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            sb_t e;
            e = sb_q.pop_front();
            check(e.tag, sample_out, e.exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_clk();
    endtask

    // Drive a phase/wave pair and queue the sample it must produce.
    task automatic drive_wave(input string tag, input logic [1:0] w, input logic [7:0] p,
                              input logic [7:0] env);
        sb_t e;
        wave_sel = w;
        phase_in = p;
        e.tag = tag;
        e.due = cyc + 2;
        e.exp = model_sample(w, p, env);
        sb_q.push_back(e);
    endtask

    // Bounded wait for the envelope to reach a value; expiry shows as a miscompare.
    task automatic wait_env(input string tag, input logic [7:0] target, input int budget);
        for (int i = 0; i < budget && env_out !== target; i++) tick_clk();
        check(tag, env_out, target);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
        for (int i = 0; i < budget && env_state !== target; i++) tick_clk();
        check(tag, env_state, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ones;
        logic [7:0] rp;
        logic [1:0] rw;

        reset = 1'b1; reset4 = 1'b1;
        phase_in = 8'h00; wave_sel = 2'd0; gate = 1'b0; gate4 = 1'b0;
        attack_rate = 4'd0; decay_rate = 4'd0; sustain_lvl = 4'hF; release_rate = 4'd0;
        #1;
        ticks(3);

        // Reset state
        check("rst_sample", sample_out, 8'h00);
        check("rst_env",    env_out,    8'h00);
        check("rst_state",  env_state,  S_IDLE);
        check("rst_pwm",    pwm_out,    1'b0);

        // ---- Attack to full scale, sustain at FF ----
        gate  = 1'b1;
        reset = 1'b0;
        ticks(100);
        check("att_env_99",   env_out,   8'd99);
        check("att_state",    env_state, S_ATTACK);
        ticks(200);
        check("full_env",     env_out,   8'hFF);
        check("full_state",   env_state, S_SUSTAIN);

        // ---- Waveform sweep through the scoreboard (env = FF) ----
        drive_wave("saw_40",   2'd0, 8'h40, 8'hFF); tick_clk();
        drive_wave("tri_40",   2'd2, 8'h40, 8'hFF); tick_clk();
        drive_wave("tri_C0",   2'd2, 8'hC0, 8'hFF); tick_clk();
        drive_wave("sq_10",    2'd1, 8'h10, 8'hFF); tick_clk();
        drive_wave("sq_90",    2'd1, 8'h90, 8'hFF); tick_clk();
        drive_wave("pul_30",   2'd3, 8'h30, 8'hFF); tick_clk();
        drive_wave("pul_50",   2'd3, 8'h50, 8'hFF); tick_clk();
        drive_wave("saw_FF",   2'd0, 8'hFF, 8'hFF); tick_clk();
        drive_wave("tri_7F",   2'd2, 8'h7F, 8'hFF); tick_clk();
        for (int i = 0; i < 24; i++) begin
            rw = 2'($urandom_range(0, 3));
            rp = 8'($urandom_range(0, 255));
            drive_wave("rnd_wave", rw, rp, 8'hFF);
            tick_clk();
        end

        // ---- Sigma-delta density with sample held at 0x40 ----
        drive_wave("sd_hold", 2'd0, 8'h41, 8'hFF);
        ticks(4);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            tick_clk();
            if (pwm_out) ones++;
        end
        check("sd_ones_64", ones, 64);
        check("sd_sample",  sample_out, 8'h40);

        // Reset mid-note clears everything at the next edge.
        reset = 1'b1;
        tick_clk();
        check("midrst_sample", sample_out, 8'h00);
        check("midrst_env",    env_out,    8'h00);
        check("midrst_state",  env_state,  S_IDLE);
        check("midrst_pwm",    pwm_out,    1'b0);
        tick_clk();
        check("midrst_hold",   env_out,    8'h00);

        // ---- Decay to sustain 0x88, then sustain_lvl change is ignored ----
        sustain_lvl = 4'h8;
        decay_rate  = 4'd0;
        reset = 1'b0;
        wait_state("dec_enter", S_DECAY, 400);
        check("dec_env_ff", env_out, 8'hFF);
        ticks(119);
        check("dec_env_88",   env_out,   8'h88);
        check("dec_state",    env_state, S_DECAY);
        tick_clk();
        check("sus_state",    env_state, S_SUSTAIN);
        check("sus_env",      env_out,   8'h88);
        sustain_lvl = 4'h2;
        ticks(20);
        check("sus_hold_env", env_out,   8'h88);
        check("sus_hold_st",  env_state, S_SUSTAIN);

        // ---- Gate drop mid-attack at 0x40, release to IDLE ----
        reset = 1'b1;
        tick_clk();
        reset = 1'b0;
        release_rate = 4'd0;
        wait_env("rel_reach_40", 8'h40, 200);
        gate = 1'b0;
        tick_clk();
        check("rel_state",   env_state, S_RELEASE);
        check("rel_env_40",  env_out,   8'h40);
        ticks(63);
        check("rel_env_01",  env_out,   8'h01);
        tick_clk();
        check("rel_env_00",  env_out,   8'h00);
        check("rel_state0",  env_state, S_RELEASE);
        tick_clk();
        check("rel_idle",    env_state, S_IDLE);

        // ---- Retrigger during release at 0x20 ----
        gate = 1'b1;
        wait_env("rtg_reach_40", 8'h40, 200);
        gate = 1'b0;
        wait_env("rtg_reach_20", 8'h20, 200);
        check("rtg_rel_state", env_state, S_RELEASE);
        gate = 1'b1;
        tick_clk();
        check("rtg_state",   env_state, S_ATTACK);
        check("rtg_env_20",  env_out,   8'h20);
        tick_clk();
        check("rtg_env_21",  env_out,   8'h21);

        // ---- Attack timing with TICK_DIV=4, attack_rate=3 ----
        reset = 1'b1;
        gate  = 1'b0;
        attack_rate = 4'd3;
        tick_clk();                  // last reset edge: prescaler at 0
        reset4 = 1'b0;
        ticks(3);                    // prescaler reaches TICK_DIV-1
        gate4 = 1'b1;
        tick_clk();                  // edge N
        check("t4_state_N",  env_state4, S_ATTACK);
        check("t4_env_N",    env_out4,   8'd0);
        ticks(15);
        check("t4_env_N15",  env_out4,   8'd0);
        tick_clk();
        check("t4_env_N16",  env_out4,   8'd1);
        ticks(15);
        check("t4_env_N31",  env_out4,   8'd1);
        tick_clk();
        check("t4_env_N32",  env_out4,   8'd2);
        ticks(16);
        check("t4_env_N48",  env_out4,   8'd3);

        if (sb_q.size() != 0) begin
            check("sb_drained", sb_q.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
